// File: rtl/dump_pkg.sv
// Shared types and constants for the reg_dump_ctrl run/halt monitor.
// Macro DUMP_HILO_EN appends hi/lo words to the record (36 instead of 34 words).
package dump_pkg;

    typedef enum logic [2:0] {IDLE, RUN, CAPTURE, DUMP, DONE} state_t;

    localparam int IDX_W = 6;
    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t IDX_STATUS = 6'd0;
    localparam idx_t IDX_PC     = 6'd1;
    localparam idx_t IDX_RF0    = 6'd2;
    localparam idx_t IDX_RF_END = 6'd34;   // one past r31
`ifdef DUMP_HILO_EN
    localparam idx_t IDX_HI     = 6'd34;
    localparam idx_t IDX_LO     = 6'd35;
    localparam int   REC_LEN    = 36;
`else
    localparam int   REC_LEN    = 34;
`endif
    localparam idx_t IDX_LAST   = idx_t'(REC_LEN - 1);

    localparam int STAT_TIMEOUT_BIT = 31;
    localparam int STAT_CNT_LSB     = 0;
    localparam int STAT_CNT_W       = 16;

    function automatic logic [31:0] make_status(input logic                  timeout,
                                                input logic [STAT_CNT_W-1:0] cnt);
        logic [31:0] w;
        w = '0;
        w[STAT_TIMEOUT_BIT] = timeout;
        w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/dump_word_mux.sv
// Selects the source of each dump word by index and drives the CPU register-file read select.
// Macro DUMP_HILO_EN adds the hi/lo sources.
module dump_word_mux
    import dump_pkg::*;
(
    input  logic        en,
    input  idx_t        idx,
    input  logic [31:0] status,
    input  logic [31:0] pc_hold,
    input  logic [31:0] reg_data,
`ifdef DUMP_HILO_EN
    input  logic [31:0] hi_data,
    input  logic [31:0] lo_data,
`endif
    output logic [4:0]  reg_sel,
    output logic [31:0] word
);

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        word    = '0;
        reg_sel = '0;
        if (en) begin
            if (idx == IDX_STATUS) begin
                word = status;
            end else if (idx == IDX_PC) begin
                word = pc_hold;
            end else if (idx < IDX_RF_END) begin
                reg_sel = 5'(idx - IDX_RF0);
                // r0 is architecturally zero whatever the read port returns
                word    = (reg_sel == 5'd0) ? 32'd0 : reg_data;
`ifdef DUMP_HILO_EN
            end else if (idx == IDX_HI) begin
                word = hi_data;
            end else if (idx == IDX_LO) begin
                word = lo_data;
`endif
            end
        end
    end

endmodule

// File: rtl/reg_dump_ctrl.sv
// Run/halt monitor for sccomp: counts cycles, stops on HALT_PC or budget, streams status/PC/r0..r31.
// Macro DUMP_HILO_EN adds hi_data/lo_data ports and two trailing record words.
module reg_dump_ctrl
    import dump_pkg::*;
#(
    parameter logic [31:0] HALT_PC    = 32'h0000_0048,
    parameter int          MAX_CYCLES = 1000,
    parameter int          CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] pc,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        cpu_run,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_data,
    output logic        dump_last,
`ifdef DUMP_HILO_EN
    input  logic [31:0] hi_data,
    input  logic [31:0] lo_data,
`endif
    output logic        done,
    output logic        timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       pc_q, pc_d;
    idx_t              idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [31:0]       data_q, data_d;
    logic              last_q, last_d;

    idx_t              mux_idx;
    logic [31:0]       mux_word;
    logic [31:0]       status;

    // The mux looks one word ahead so reg_sel settles before the load edge.
    assign mux_idx = (state_q == DUMP) ? idx_q + idx_t'(1) : IDX_STATUS;
    assign status  = make_status(timeout_q, STAT_CNT_W'(cnt_q));

    dump_word_mux u_mux (
        .en       (state_q == CAPTURE || state_q == DUMP),
        .idx      (mux_idx),
        .status   (status),
        .pc_hold  (pc_q),
        .reg_data (reg_data),
`ifdef DUMP_HILO_EN
        .hi_data  (hi_data),
        .lo_data  (lo_data),
`endif
        .reg_sel  (reg_sel),
        .word     (mux_word)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        pc_d      = pc_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            RUN: begin
                // Halt is tested first so it wins over a budget hit in the same cycle.
                if (pc == HALT_PC) begin
                    state_d = CAPTURE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: begin
                pc_d    = pc;
                idx_d   = IDX_STATUS;
                data_d  = mux_word;
                last_d  = 1'b0;
                valid_d = 1'b1;
                state_d = DUMP;
            end
            DUMP: begin
                if (valid_q && dump_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        idx_d  = mux_idx;
                        data_d = mux_word;
                        last_d = (mux_idx == IDX_LAST);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            pc_q      <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            pc_q      <= pc_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
        end
    end

    assign cpu_run    = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign timeout    = timeout_q;
    assign dump_valid = valid_q;
    assign dump_data  = data_q;
    assign dump_last  = last_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed self-checking bench for reg_dump_ctrl with a tiny sccomp stand-in (PC stepper + RF array).
// Define DUMP_HILO_EN to exercise the 36-word record.
module tb_reg_dump_ctrl;
    import dump_pkg::*;

    localparam logic [31:0] HALT = 32'h0000_0048;
    localparam int          MAXC = 20;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc_m;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        cpu_run;
    logic        dump_valid;
    logic        dump_ready = 1'b1;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        done;
    logic        timeout;
`ifdef DUMP_HILO_EN
    logic [31:0] hi_data = 32'hDEAD_0001;
    logic [31:0] lo_data = 32'hBEEF_0002;
`endif

    logic [31:0] rf [32];
    logic [31:0] pc_init = '0;
    logic        pc_load = 1'b0;
    logic        loop_mode = 1'b0;

    int total = 0;
    int bad = 0;

    logic [31:0] beats [$];
    logic        lasts [$];
    int          acc_cyc [$];
    int          run_cycles;
    int          stall_errs;

    always #5 clk = ~clk;

    // CPU stand-in: advances by 4 per enabled cycle and parks on the halt PC (self-loop).
    always @(posedge clk) begin
        if (pc_load)
            pc_m <= pc_init;
        else if (cpu_run && !loop_mode && pc_m != HALT)
            pc_m <= pc_m + 32'd4;
    end

    assign reg_data = rf[reg_sel];

    reg_dump_ctrl #(.HALT_PC(HALT), .MAX_CYCLES(MAXC), .CNT_W(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .pc         (pc_m),
        .reg_sel    (reg_sel),
        .reg_data   (reg_data),
        .cpu_run    (cpu_run),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
`ifdef DUMP_HILO_EN
        .hi_data    (hi_data),
        .lo_data    (lo_data),
`endif
        .done       (done),
        .timeout    (timeout)
    );

    function automatic logic [31:0] exp_word(input int i, input logic [31:0] st, input logic [31:0] pcv);
        if (i == 0) return st;
        if (i == 1) return pcv;
        if (i == 2) return 32'd0;
        if (i < 34) return rf[i-2];
`ifdef DUMP_HILO_EN
        if (i == 34) return 32'hDEAD_0001;
        if (i == 35) return 32'hBEEF_0002;
`endif
        return 32'd0;
    endfunction

    function automatic int record_errors(input logic [31:0] st, input logic [31:0] pcv);
        int n = 0;
        for (int i = 0; i < beats.size(); i++) begin
            if (beats[i] !== exp_word(i, st, pcv)) n++;
            if (lasts[i] !== (i == REC_LEN - 1)) n++;
        end
        return n;
    endfunction

    task automatic do_run(input logic [31:0] init_pc, input bit lp, input bit bp, input int abort_after);
        bit finished = 0;
        bit prev_stall = 0;
        logic [31:0] prev_data = '0;
        logic pat [4];
        int k = 0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        beats.delete(); lasts.delete(); acc_cyc.delete();
        run_cycles = 0;
        stall_errs = 0;
        @(negedge clk);
        pc_init = init_pc; loop_mode = lp; pc_load = 1'b1;
        @(negedge clk);
        pc_load = 1'b0; start = 1'b1; dump_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cpu_run) run_cycles++;
            if (prev_stall && (!dump_valid || dump_data !== prev_data)) stall_errs++;
            dump_ready = bp ? pat[k % 4] : 1'b1;
            prev_stall = 0;
            if (dump_valid) begin
                k++;
                if (dump_ready) begin
                    beats.push_back(dump_data);
                    lasts.push_back(dump_last);
                    acc_cyc.push_back(cyc);
                end else begin
                    prev_stall = 1;
                    prev_data  = dump_data;
                end
            end
            if (abort_after != 0 && beats.size() == abort_after) finished = 1;
            if (done) finished = 1;
        end
        dump_ready = 1'b1;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL run_bound: got no done within 400 cycles, required done");
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (cpu_run !== 1'b0)    begin bad++; $display("FAIL rst_cpu_run: got %b required 0", cpu_run); end
        total++; if (dump_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", dump_valid); end
        total++; if (dump_data !== 32'd0) begin bad++; $display("FAIL rst_data: got %h required 0", dump_data); end
        total++; if (dump_last !== 1'b0)  begin bad++; $display("FAIL rst_last: got %b required 0", dump_last); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL rst_done: got %b required 0", done); end
        total++; if (timeout !== 1'b0)    begin bad++; $display("FAIL rst_timeout: got %b required 0", timeout); end
        total++; if (reg_sel !== 5'd0)    begin bad++; $display("FAIL rst_reg_sel: got %0d required 0", reg_sel); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_halt;
        int e;
        do_run(32'h4, 1'b0, 1'b0, 0);
        total++; if (run_cycles != 18) begin bad++; $display("FAIL halt_run_cycles: got %0d required 18", run_cycles); end
        total++; if (beats.size() != REC_LEN) begin bad++; $display("FAIL halt_beats: got %0d required %0d", beats.size(), REC_LEN); end
        if (beats.size() >= 10) begin
            total++; if (beats[0] !== 32'h0000_0011) begin bad++; $display("FAIL halt_word0: got %h required 00000011", beats[0]); end
            total++; if (beats[1] !== 32'h0000_0048) begin bad++; $display("FAIL halt_word1: got %h required 00000048", beats[1]); end
            total++; if (beats[2] !== 32'h0)         begin bad++; $display("FAIL halt_r0: got %h required 00000000", beats[2]); end
            total++; if (beats[9] !== rf[7])         begin bad++; $display("FAIL halt_r7: got %h required %h", beats[9], rf[7]); end
        end
        e = record_errors(32'h0000_0011, HALT);
        total++; if (e != 0) begin bad++; $display("FAIL halt_record: got %0d bad words required 0", e); end
        if (acc_cyc.size() > 0) begin
            total++;
            if (acc_cyc[acc_cyc.size()-1] - acc_cyc[0] != REC_LEN - 1) begin
                bad++; $display("FAIL halt_throughput: got span %0d required %0d", acc_cyc[acc_cyc.size()-1] - acc_cyc[0], REC_LEN - 1);
            end
        end
        total++; if (done !== 1'b1)    begin bad++; $display("FAIL halt_done: got %b required 1", done); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL halt_timeout: got %b required 0", timeout); end
        total++; if (cpu_run !== 1'b0 || dump_valid !== 1'b0 || reg_sel !== 5'd0) begin
            bad++; $display("FAIL done_outputs: got run=%b valid=%b sel=%0d required 0/0/0", cpu_run, dump_valid, reg_sel);
        end
    endtask

    task automatic test_timeout;
        int e;
        do_run(32'h100, 1'b1, 1'b0, 0);
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_timeout: got %b required 1", timeout); end
        total++; if (run_cycles != MAXC) begin bad++; $display("FAIL to_run_cycles: got %0d required %0d", run_cycles, MAXC); end
        total++; if (beats.size() != REC_LEN) begin bad++; $display("FAIL to_beats: got %0d required %0d", beats.size(), REC_LEN); end
        if (beats.size() > 0) begin
            total++; if (beats[0] !== 32'h8000_0013) begin bad++; $display("FAIL to_word0: got %h required 80000013", beats[0]); end
        end
        e = record_errors(32'h8000_0013, 32'h100);
        total++; if (e != 0) begin bad++; $display("FAIL to_record: got %0d bad words required 0", e); end
    endtask

    task automatic test_backpressure;
        int e;
        do_run(32'h4, 1'b0, 1'b1, 0);
        total++; if (beats.size() != REC_LEN) begin bad++; $display("FAIL bp_beats: got %0d required %0d", beats.size(), REC_LEN); end
        total++; if (stall_errs != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable stalls required 0", stall_errs); end
        e = record_errors(32'h0000_0011, HALT);
        total++; if (e != 0) begin bad++; $display("FAIL bp_record: got %0d bad words required 0", e); end
    endtask

    task automatic test_simultaneous;
        // PC reaches HALT on count 19 == MAX_CYCLES-1
        do_run(32'hFFFF_FFFC, 1'b0, 1'b0, 0);
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL sim_timeout: got %b required 0", timeout); end
        if (beats.size() > 1) begin
            total++; if (beats[0] !== 32'h0000_0013) begin bad++; $display("FAIL sim_word0: got %h required 00000013", beats[0]); end
            total++; if (beats[1] !== HALT) begin bad++; $display("FAIL sim_word1: got %h required %h", beats[1], HALT); end
        end
    endtask

    task automatic test_reset_mid_dump;
        int e;
        do_run(32'h4, 1'b0, 1'b0, 10);
        rstn = 1'b0;
        #1;
        total++; if (dump_valid !== 1'b0 || cpu_run !== 1'b0 || done !== 1'b0 || dump_last !== 1'b0) begin
            bad++; $display("FAIL mid_rst: got valid=%b run=%b done=%b last=%b required all 0", dump_valid, cpu_run, done, dump_last);
        end
        @(negedge clk);
        rstn = 1'b1;
        do_run(32'h4, 1'b0, 1'b0, 0);
        total++; if (beats.size() != REC_LEN) begin bad++; $display("FAIL mid_rerun_beats: got %0d required %0d", beats.size(), REC_LEN); end
        e = record_errors(32'h0000_0011, HALT);
        total++; if (e != 0) begin bad++; $display("FAIL mid_rerun_record: got %0d bad words required 0", e); end
    endtask

    initial begin
        rf[0] = 32'hFFFF_FFFF;
        for (int i = 1; i < 32; i++) rf[i] = 32'hA500_0000 | (i << 8) | i;
        test_reset();
        test_halt();
        test_timeout();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_dump_ctrl.md
Name: reg_dump_ctrl

Overview:
- Synthesizable run/halt monitor sitting downstream of sccomp; consumes its PC and its reg_sel/reg_data debug read port.
- Counts executed cycles and detects the halt PC or a cycle-budget timeout.
- On either event, freezes the CPU and streams a result record out over a valid/ready port: status word, PC, then r0..r31.
- Replaces simulation-only $fdisplay dumps on board and in regression benches.

Parameters:
- HALT_PC, 32'h00000048, PC value that ends a run.
- MAX_CYCLES, 1000, cycle budget before timeout; must be at least 1.
- CNT_W, 16, width of the cycle counter; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clk  in  1  system clock, shared with sccomp.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run (ignored outside IDLE/DONE).
- pc  in  32  current PC from sccomp.
- reg_sel  out  5  register index to sccomp debug read port.
- reg_data  in  32  combinational RF read of reg_sel (same-cycle).
- cpu_run  out  1  clock-enable/hold to sccomp; 1 = execute.
- dump_valid  out  1  dump word available.
- dump_ready  in  1  consumer accepts the word when valid&ready.
- dump_data  out  32  dump word.
- dump_last  out  1  marks the final word of a record.
- done  out  1  high in DONE.
- timeout  out  1  sticky; run ended by budget, not HALT_PC.

Behaviour:
- Reset (async, rstn=0): state=IDLE, cpu_run=0, reg_sel=0, dump_valid=0, dump_data=0, dump_last=0, done=0, timeout=0, cycle counter=0, word index=0.
- States: IDLE, RUN, CAPTURE, DUMP, DONE.
- IDLE/DONE + start=1 -> RUN next cycle. On entry: counter=0, timeout=0, done=0, cpu_run=1.
- RUN:
  - Counter increments each cycle.
  - If pc==HALT_PC -> CAPTURE.
  - Else if counter==MAX_CYCLES-1 -> timeout=1, CAPTURE.
  - If both occur in the same cycle, halt wins and timeout stays 0.
  - cpu_run drops to 0 in the cycle the transition is registered; the CPU executes exactly counter+1 cycles.
- CAPTURE (one cycle):
  - Latch pc into a PC holding register.
  - Word index=0.
  - Drive the first word: status = {timeout, 15'b0, counter[15:0] zero-extended/truncated}.
  - Set dump_valid=1 -> DUMP.
- DUMP:
  - Word sequence: idx0 status, idx1 PC, idx2..33 = reg_data with reg_sel=idx-2 (r0 reported as 0 regardless of reg_data).
  - On valid&ready, dump_data/dump_last load the next word the following cycle (registered output, one word per cycle at full throughput).
  - reg_sel is driven one cycle ahead so reg_data is sampled combinationally at the load.
  - dump_data is held stable while valid&!ready.
  - dump_last=1 on the final word. Its acceptance -> DONE, dump_valid=0.
- DONE: done=1, cpu_run=0, reg_sel=0. A new start re-runs without reset; the CPU state is not reset by this block.
- start during RUN/CAPTURE/DUMP is ignored.
- rstn asserted mid-dump: immediate return to reset values; the partial record is abandoned, with no last beat.
- Counter saturates at MAX_CYCLES-1; no wrap.

Optional Feature:
- Macro DUMP_HILO_EN.
- When defined: extra ports hi_data and lo_data, in, 32 each. Two extra words (hi, then lo) are appended after r31. dump_last moves to lo, giving a 36-word record.
- When undefined: no extra ports; 34-word record, last on r31.

Decomposition:
- Package dump_pkg holds:
  - state enum (IDLE, RUN, CAPTURE, DUMP, DONE);
  - word index constants IDX_STATUS=0, IDX_PC=1, IDX_RF0=2;
  - record length constants REC_LEN=34, and REC_LEN=36 when DUMP_HILO_EN is defined;
  - status-word field positions.
- One natural sub-module: dump_word_mux, which maps word index to its data source (status/PC/RF/hi/lo) and generates reg_sel.

Test Plan:
- Halt path: program reaches PC 0x48 at cycle 17, ready tied 1 -> cpu_run drops after 18 cycles; 34 consecutive beats; word0=0x00000011, word1=0x00000048, word9=r7 value; dump_last only on beat 34; done=1.
- Timeout: MAX_CYCLES=20, infinite loop -> timeout=1, word0=0x80000013; record still 34 words.
- Backpressure: ready toggles 1,0,0,1 pattern -> no word dropped or duplicated; dump_data stable while stalled; total accepted beats=34.
- Simultaneous halt and budget: pc==HALT_PC on cycle MAX_CYCLES-1 -> timeout=0.
- Reset mid-dump: rstn low after beat 10 -> dump_valid=0, cpu_run=0, state IDLE within the same cycle. A later start yields a full clean record.
- DUMP_HILO_EN defined, hi=0xDEAD0001, lo=0xBEEF0002 -> beats 35/36 carry those values; last on beat 36.
